pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipelined ARM CPU. It detects load-use hazards that the forwarding units (ALU-operand and CBZ-value forwarding) cannot cover, and inserts the required number of ID/EX bubbles with a counter-driven FSM. It freezes the whole pipeline while a variable-latency data-memory access is outstanding, and gates the taken-branch flush of IF/ID. It sits beside the forwarding units and drives the write-enables of PC, IF/ID and the ID/EX bubble mux.

---
 rtl/pipeline_hazard_pkg.sv | 25 ++
 rtl/pipeline_hazard_ctrl_depth.sv | 45 ++++
 rtl/pipeline_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_pkg.sv
// rtl/pipeline_hazard_pkg.sv - shared types, field positions and match helper for the hazard controller
package pipeline_hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam int RT_LSB = 0;
  localparam int RN_LSB = 5;
  localparam int RM_LSB = 16;
  localparam int REG_W  = 5;

  localparam logic [REG_W-1:0] ZERO_REG_DEF = 5'd31;

  // XZR never carries a value worth waiting for
  function automatic logic reg_match(input logic [REG_W-1:0] dest,
                                     input logic [REG_W-1:0] src,
                                     input logic             used,
                                     input logic [REG_W-1:0] zero_reg);
    return used && (dest == src) && (dest != zero_reg);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_depth.sv
// rtl/pipeline_hazard_ctrl_depth.sv - combinational load-use hazard depth (bubbles needed: 0, 1 or 2)
module hazard_depth_calc
  import pipeline_hazard_pkg::*;
#(
  parameter logic [REG_W-1:0] ZERO_REG = ZERO_REG_DEF
) (
  input  logic [31:0] id_instr,
  input  logic [31:0] ex_instr,
  input  logic [31:0] mem_instr,
  input  logic        id_is_cbz,
  input  logic        id_uses_rn,
  input  logic        id_uses_rm,
  input  logic        ex_mem_read,
  input  logic        mem_mem_read,
  output logic [1:0]  depth
);

  logic [REG_W-1:0] id_rt, id_rn, id_rm, ex_dest, mem_dest;
  logic             cbz_on_ex_load, cbz_on_mem_load, alu_on_ex_load;
  logic             unused_bits;

  assign id_rt    = id_instr[RT_LSB +: REG_W];
  assign id_rn    = id_instr[RN_LSB +: REG_W];
  assign id_rm    = id_instr[RM_LSB +: REG_W];
  assign ex_dest  = ex_instr[RT_LSB +: REG_W];
  assign mem_dest = mem_instr[RT_LSB +: REG_W];

  assign unused_bits = ^{id_instr[31:21], id_instr[15:10], ex_instr[31:5], mem_instr[31:5]};

  // CBZ resolves in ID, so it needs the loaded value one stage earlier than the ALU does
  assign cbz_on_ex_load  = id_is_cbz & ex_mem_read  & reg_match(ex_dest,  id_rt, 1'b1, ZERO_REG);
  assign cbz_on_mem_load = id_is_cbz & mem_mem_read & reg_match(mem_dest, id_rt, 1'b1, ZERO_REG);
  assign alu_on_ex_load  = ex_mem_read & (reg_match(ex_dest, id_rn, id_uses_rn, ZERO_REG) |
                                          reg_match(ex_dest, id_rm, id_uses_rm, ZERO_REG));

  always_comb begin
    depth = 2'd0;
    if (cbz_on_ex_load) begin
      depth = 2'd2;
    end else if (cbz_on_mem_load || alu_on_ex_load) begin
      depth = 2'd1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use stall, memory-wait freeze and branch-flush sequencer
// Optional: STALL_STATS_EN adds the saturating stall_cycles counter output.
module pipeline_hazard_ctrl
  import pipeline_hazard_pkg::*;
#(
  parameter logic [REG_W-1:0] ZERO_REG    = ZERO_REG_DEF,
  parameter int               MEM_TIMEOUT = 64,
  parameter int               CNT_W       = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] id_instr,
  input  logic [31:0] ex_instr,
  input  logic [31:0] mem_instr,
  input  logic        id_is_cbz,
  input  logic        id_uses_rn,
  input  logic        id_uses_rm,
  input  logic        ex_mem_read,
  input  logic        mem_mem_read,
  input  logic        mem_access,
  input  logic        mem_ready,
  input  logic        id_branch_taken,
  output logic        pc_write_en,
  output logic        if_id_write_en,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        pipe_freeze,
  output logic        mem_timeout
`ifdef STALL_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state, state_nxt, ret_state, ret_state_nxt;
  logic [1:0]        stall_cnt, stall_cnt_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [1:0]        depth;
  logic              mem_busy;
  logic              timeout_q, timeout_hit;

  hazard_depth_calc #(
    .ZERO_REG(ZERO_REG)
  ) u_depth (
    .id_instr    (id_instr),
    .ex_instr    (ex_instr),
    .mem_instr   (mem_instr),
    .id_is_cbz   (id_is_cbz),
    .id_uses_rn  (id_uses_rn),
    .id_uses_rm  (id_uses_rm),
    .ex_mem_read (ex_mem_read),
    .mem_mem_read(mem_mem_read),
    .depth       (depth)
  );

  assign mem_busy    = mem_access & ~mem_ready;
  assign timeout_hit = (state == MEM_WAIT) && (wait_cnt == WAIT_LAST);
  assign mem_timeout = timeout_q | timeout_hit;

  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    pipe_freeze    = 1'b0;
    state_nxt      = state;
    ret_state_nxt  = ret_state;
    stall_cnt_nxt  = stall_cnt;
    wait_cnt_nxt   = wait_cnt;

    case (state)
      RUN: begin
        if (mem_busy) begin
          pipe_freeze    = 1'b1;
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          ret_state_nxt  = RUN;
          state_nxt      = MEM_WAIT;
        end else if (depth != 2'd0) begin
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          id_ex_bubble   = 1'b1;
          stall_cnt_nxt  = depth - 2'd1;
          state_nxt      = (depth == 2'd2) ? STALL : RUN;
        end else begin
          if_id_flush = id_branch_taken;
        end
      end

      // the branch is still being resolved on stale data here, so no flush
      STALL: begin
        if (mem_busy) begin
          pipe_freeze    = 1'b1;
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          ret_state_nxt  = STALL;
          state_nxt      = MEM_WAIT;
        end else begin
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          id_ex_bubble   = 1'b1;
          stall_cnt_nxt  = (stall_cnt == 2'd0) ? 2'd0 : stall_cnt - 2'd1;
          if (stall_cnt <= 2'd1) begin
            state_nxt = RUN;
          end
        end
      end

      // the ready cycle is still frozen: the access retires as the pipe advances
      MEM_WAIT: begin
        pipe_freeze    = 1'b1;
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        if (mem_ready) begin
          wait_cnt_nxt = '0;
          state_nxt    = ret_state;
        end else if (wait_cnt != WAIT_LAST) begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= RUN;
      ret_state <= RUN;
      stall_cnt <= 2'd0;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_state_nxt;
      stall_cnt <= stall_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

`ifdef STALL_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (id_ex_bubble && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench with a bubble-count reference model for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] id_instr, ex_instr, mem_instr;
  logic        id_is_cbz, id_uses_rn, id_uses_rm;
  logic        ex_mem_read, mem_mem_read, mem_access, mem_ready, id_branch_taken;
  logic        pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, pipe_freeze, mem_timeout;
`ifdef STALL_STATS_EN
  logic [31:0] stall_cycles;
`endif

  pipeline_hazard_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .id_instr       (id_instr),
    .ex_instr       (ex_instr),
    .mem_instr      (mem_instr),
    .id_is_cbz      (id_is_cbz),
    .id_uses_rn     (id_uses_rn),
    .id_uses_rm     (id_uses_rm),
    .ex_mem_read    (ex_mem_read),
    .mem_mem_read   (mem_mem_read),
    .mem_access     (mem_access),
    .mem_ready      (mem_ready),
    .id_branch_taken(id_branch_taken),
    .pc_write_en    (pc_write_en),
    .if_id_write_en (if_id_write_en),
    .if_id_flush    (if_id_flush),
    .id_ex_bubble   (id_ex_bubble),
    .pipe_freeze    (pipe_freeze),
    .mem_timeout    (mem_timeout)
`ifdef STALL_STATS_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected vector order: {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, pipe_freeze, mem_timeout}
  logic [5:0] exp_q[$];
  logic [5:0] exp_v, act_v;
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  bit         done   = 1'b0;

  // reference model: bubbles still owed, whether we are waiting on memory, and how long
  int m_owed, m_wcnt, m_bubbles;
  bit m_waiting, m_tout;

  function automatic bit hit(input logic [4:0] d, input logic [4:0] s, input bit used);
    return used && (d == s) && (d != 5'd31);
  endfunction

  function automatic int needed_bubbles();
    logic [4:0] rt, rn, rm, ed, md;
    rt = id_instr[4:0];
    rn = id_instr[9:5];
    rm = id_instr[20:16];
    ed = ex_instr[4:0];
    md = mem_instr[4:0];
    if (id_is_cbz && ex_mem_read && hit(ed, rt, 1'b1)) return 2;
    if (id_is_cbz && mem_mem_read && hit(md, rt, 1'b1)) return 1;
    if (ex_mem_read && (hit(ed, rn, id_uses_rn) || hit(ed, rm, id_uses_rm))) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] rt, input logic [4:0] rn, input logic [4:0] rm);
    logic [31:0] r;
    r = $urandom;
    r[4:0]   = rt;
    r[9:5]   = rn;
    r[20:16] = rm;
    return r;
  endfunction

  function automatic logic [4:0] pick();
    logic [4:0] r;
    case ($urandom_range(0, 3))
      0: r = 5'd3;
      1: r = 5'd7;
      2: r = 5'd31;
      default: r = 5'($urandom_range(0, 31));
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_owed = 0; m_wcnt = 0; m_bubbles = 0; m_waiting = 1'b0; m_tout = 1'b0;
  endtask

  task automatic quiet();
    id_instr = 32'h0; ex_instr = 32'h0; mem_instr = 32'h0;
    id_is_cbz = 1'b0; id_uses_rn = 1'b0; id_uses_rm = 1'b0;
    ex_mem_read = 1'b0; mem_mem_read = 1'b0;
    mem_access = 1'b0; mem_ready = 1'b1; id_branch_taken = 1'b0;
  endtask

  // inputs are already applied; predict this cycle, advance the model, then clock
  task automatic tick();
    bit pc, ifid, fl, bub, frz, to;
    int n;
    pc = 1'b1; ifid = 1'b1; fl = 1'b0; bub = 1'b0; frz = 1'b0;
    to = m_tout || (m_waiting && m_wcnt == 63);
    if (m_waiting) begin
      frz = 1'b1; pc = 1'b0; ifid = 1'b0;
      if (mem_ready) begin
        m_waiting = 1'b0; m_wcnt = 0;
      end else if (m_wcnt < 63) begin
        m_wcnt++;
      end
    end else if (mem_access && !mem_ready) begin
      frz = 1'b1; pc = 1'b0; ifid = 1'b0;
      m_waiting = 1'b1;
    end else if (m_owed > 0) begin
      bub = 1'b1; pc = 1'b0; ifid = 1'b0;
      m_owed--;
    end else begin
      n = needed_bubbles();
      if (n > 0) begin
        bub = 1'b1; pc = 1'b0; ifid = 1'b0;
        m_owed = n - 1;
      end else begin
        fl = id_branch_taken;
      end
    end
    m_tout = to;
    if (bub) m_bubbles++;
    exp_q.push_back({pc, ifid, fl, bub, frz, to});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    quiet();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic cbz_on_ex_load();
    quiet();
    ex_instr = mk(5'd3, 5'd0, 5'd0); ex_mem_read = 1'b1;
    id_instr = mk(5'd3, 5'd9, 5'd10); id_is_cbz = 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, pipe_freeze, mem_timeout};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL outputs cycle %0d: got %b expected %b (pc_we,ifid_we,flush,bubble,freeze,timeout)",
                 cyc, act_v, exp_v);
      end
    end else if (done) begin
      checks++;
      if (cyc < 100) begin
        errors++;
        $display("FAIL run_length: got %0d cycles required at least 100", cyc);
      end
`ifdef STALL_STATS_EN
      checks++;
      if (stall_cycles !== 32'(m_bubbles)) begin
        errors++;
        $display("FAIL stall_cycles: got %0d expected %0d", stall_cycles, m_bubbles);
      end
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    quiet();
    reset = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    tick(); tick();

    // CBZ on a load in EX: two bubbles, then defaults
    cbz_on_ex_load(); tick(); tick();
    quiet(); tick(); tick();

    // ALU operand on load in EX: one bubble; XZR destination: none
    ex_instr = mk(5'd3, 5'd0, 5'd0); ex_mem_read = 1'b1;
    id_instr = mk(5'd5, 5'd3, 5'd4); id_uses_rn = 1'b1; id_uses_rm = 1'b1;
    tick(); quiet(); tick();
    ex_instr = mk(5'd31, 5'd0, 5'd0); ex_mem_read = 1'b1;
    id_instr = mk(5'd5, 5'd31, 5'd4); id_uses_rn = 1'b1;
    tick(); quiet(); tick();

    // CBZ on a load in MEM: one bubble; ALU result in EX is forwarded
    mem_instr = mk(5'd7, 5'd0, 5'd0); mem_mem_read = 1'b1;
    id_instr = mk(5'd7, 5'd1, 5'd2); id_is_cbz = 1'b1;
    tick(); quiet(); tick();
    ex_instr = mk(5'd7, 5'd0, 5'd0);
    id_instr = mk(5'd7, 5'd1, 5'd2); id_is_cbz = 1'b1;
    tick(); quiet(); tick();

    // memory stall in the first STALL cycle
    cbz_on_ex_load(); tick();
    quiet(); mem_access = 1'b1; mem_ready = 1'b0;
    tick(); tick(); tick();
    mem_ready = 1'b1; tick();
    quiet(); tick(); tick(); tick();

    // taken branch in RUN flushes, in STALL it does not
    quiet(); id_branch_taken = 1'b1; tick();
    quiet(); tick();
    cbz_on_ex_load(); tick();
    quiet(); id_branch_taken = 1'b1; tick();
    quiet(); tick();

    // timeout, then reset out of MEM_WAIT
    mem_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 70; i++) tick();
    do_reset();
    tick(); tick();

    for (int i = 0; i < 500; i++) begin
      quiet();
      id_instr        = mk(pick(), pick(), pick());
      ex_instr        = mk(pick(), pick(), pick());
      mem_instr       = mk(pick(), pick(), pick());
      id_is_cbz       = ($urandom_range(0, 2) == 0);
      id_uses_rn      = $urandom_range(0, 1) == 1;
      id_uses_rm      = $urandom_range(0, 1) == 1;
      ex_mem_read     = $urandom_range(0, 1) == 1;
      mem_mem_read    = $urandom_range(0, 1) == 1;
      mem_access      = ($urandom_range(0, 3) == 0);
      mem_ready       = ($urandom_range(0, 9) < 6);
      id_branch_taken = ($urandom_range(0, 3) == 0);
      tick();
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    quiet();
    tick();
    done = 1'b1;
  end

endmodule
